run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Run controller for the single-cycle processor top level.
- Sequences a program run: hold core in reset, release, count cycles, detect done or timeout.
- Arbitrates the single data-memory port (256 x 8) between a host loader/readback port and the core.
- The host owns data memory whenever the core is not running. The core owns it only during RUN.

Parameters:
CNT_W, 16, width of the cycle counter
MAX_CYCLES, 1000, cycle count at which RUN aborts to timeout (must be < 2^CNT_W)
INIT_CYCLES, 2, number of cycles the core is held in reset before release (>= 1)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  host run request, level-sampled
HostReq  in  1  host requests data-memory access
HostWrEn  in  1  host write strobe (honoured only when HostGnt=1)
HostAddr  in  8  host memory address
HostWrData  in  8  host write data
HostGnt  out  1  host owns memory this cycle
HostRdData  out  8  read data to host
CoreDone  in  1  core's done flag (its Ack)
CoreMemWrEn  in  1  core data-memory write enable
CoreMemAddr  in  8  core data-memory address
CoreMemWrData  in  8  core write data
CoreRdData  out  8  read data to core
CoreReset  out  1  active-high reset to core
CoreStart  out  1  core Start (holds PC while high)
DmWrEn  out  1  to data memory
DmAddr  out  8  to data memory
DmWrData  out  8  to data memory
DmRdData  in  8  data-memory combinational read data
Ack  out  1  run completed normally
Busy  out  1  run in progress (INIT or RUN)
Timeout  out  1  run aborted at MAX_CYCLES
CycleCount  out  CNT_W  RUN cycles of the last or current run

Behaviour:
Reset (Reset=0, async):
- state=IDLE; CoreReset=1, CoreStart=1.
- Ack=0, Busy=0, Timeout=0, CycleCount=0, init counter=0.
- Effective immediately, including mid-run. Data memory contents are untouched.

Ownership and port mux:
- Host owns memory in IDLE, DONE and TOUT. HostGnt = HostReq & host-owned (combinational).
- Host-owned: DmAddr=HostAddr, DmWrData=HostWrData, DmWrEn=HostWrEn&HostReq.
- RUN: DmAddr/DmWrData/DmWrEn come from the core.
- INIT: DmWrEn=0 and DmAddr=CoreMemAddr.
- HostRdData=DmRdData and CoreRdData=DmRdData at all times; read latency 0, write takes effect on the next rising edge.

States (registered, next-state on rising Clk):
- IDLE: CoreReset=1, CoreStart=1.
  - Start=1 & HostReq=0 -> INIT.
  - Start with HostReq=1: ignored this cycle (host priority), remain IDLE.
- INIT: CoreReset=1, CoreStart=1, Busy=1.
  - On entry: CycleCount:=0, Ack:=0, Timeout:=0.
  - Counts INIT_CYCLES cycles, then -> RUN.
- RUN: CoreReset=0, CoreStart=0, Busy=1, HostGnt=0.
  - CycleCount increments every cycle.
  - CoreDone=1 -> DONE, with Ack:=1 on the same edge.
  - Else if CycleCount==MAX_CYCLES-1 -> TOUT, with Timeout:=1.
  - CoreDone and timeout in the same cycle: DONE wins.
- DONE: Ack=1 held, Busy=0, CoreReset=0 (register file stays observable), CoreStart=1 (PC frozen). CycleCount frozen.
  - Start=1 & HostReq=0 -> INIT.
- TOUT: same as DONE, except Timeout=1 and Ack=0.

Other rules:
- CycleCount counts whole RUN cycles; a program finishing on its 5th RUN cycle reports 5.
- The counter never wraps: it saturates at 2^CNT_W-1. This is only reachable when the timeout is compiled out.
- Ack, Timeout, Busy and CycleCount are registered outputs; no combinational path from CoreDone.
- Start held high across DONE re-launches every run (back-to-back runs are legal).

Optional Feature:
RUN_CTRL_TIMEOUT_EN
- Defined: TOUT state and MAX_CYCLES abort exist as above.
- Undefined: TOUT is removed and Timeout is tied 0. RUN exits only on CoreDone or Reset, and CycleCount saturates.

Test Plan:
1. Reset=0 mid-RUN at CycleCount=7 -> same timestep: CoreReset=1, Busy=0, CycleCount=0, state IDLE; memory word 54 still holds 15.
2. IDLE, HostReq=1, HostWrEn=1, HostAddr=1, HostWrData=8'h03 -> HostGnt=1, DmWrEn=1; next cycle a read of addr 1 gives HostRdData=8'h03.
3. Start=1 with HostReq=1 for 3 cycles -> stays IDLE, Busy=0. Drop HostReq -> INIT for exactly 2 cycles (CoreReset=1), then RUN with CoreReset=0, CoreStart=0.
4. RUN; core writes addr 7 = 9 while host drives HostReq=1, HostAddr=7, HostWrData=8'hAA -> HostGnt=0, memory[7]=9.
5. CoreDone asserted on the 5th RUN cycle -> Ack=1, Busy=0, CycleCount=5, host regains access. Start again -> Ack=0 in INIT, CycleCount=0.
6. MAX_CYCLES=20, CoreDone held 0 -> Timeout=1, Ack=0 after 20 RUN cycles, CycleCount=20.
   - With CoreDone=1 on cycle 20: Ack=1, Timeout=0.
   - Macro undefined: Timeout stays 0 and the run continues.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller: sequences a core run (hold in reset, release, count, done/timeout)
// and arbitrates the single data-memory port. Timeout abort enabled by RUN_CTRL_TIMEOUT_EN.
module run_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 1000,
  parameter int INIT_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HostReq,
  input  logic             HostWrEn,
  input  logic [7:0]       HostAddr,
  input  logic [7:0]       HostWrData,
  output logic             HostGnt,
  output logic [7:0]       HostRdData,
  input  logic             CoreDone,
  input  logic             CoreMemWrEn,
  input  logic [7:0]       CoreMemAddr,
  input  logic [7:0]       CoreMemWrData,
  output logic [7:0]       CoreRdData,
  output logic             CoreReset,
  output logic             CoreStart,
  output logic             DmWrEn,
  output logic [7:0]       DmAddr,
  output logic [7:0]       DmWrData,
  input  logic [7:0]       DmRdData,
  output logic             Ack,
  output logic             Busy,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [2:0]       DbgState
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_TOUT = 3'd4;

  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;
`ifdef RUN_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              tout_q, tout_d;
  logic              busy_q, busy_d;
  logic              launch;
  logic              host_owned;

  // Host has priority: a Start seen together with HostReq is dropped for that cycle.
  assign launch = Start & ~HostReq;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    tout_d     = tout_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (launch) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          cnt_d      = '0;
          ack_d      = 1'b0;
          tout_d     = 1'b0;
        end
      end
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = S_RUN;
        else                         init_cnt_d = init_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        // Done outranks a timeout landing on the same cycle.
        if (CoreDone) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
        end
`ifdef RUN_CTRL_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = S_TOUT;
          tout_d  = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_INIT) || (state_d == S_RUN);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      tout_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tout_q     <= tout_d;
      busy_q     <= busy_d;
    end
  end

  // Host request/grant: HostGnt = HostReq while the core is not running; a host write
  // lands on the next rising edge only when granted, reads return DmRdData the same cycle.
  assign host_owned = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_TOUT);
  assign HostGnt    = HostReq & host_owned;

  always_comb begin
    DmAddr   = CoreMemAddr;
    DmWrData = CoreMemWrData;
    DmWrEn   = 1'b0;
    if (host_owned) begin
      DmAddr   = HostAddr;
      DmWrData = HostWrData;
      DmWrEn   = HostWrEn & HostReq;
    end else if (state_q == S_RUN) begin
      DmWrEn   = CoreMemWrEn;
    end
  end

  assign HostRdData = DmRdData;
  assign CoreRdData = DmRdData;
  assign CoreReset  = (state_q == S_IDLE) || (state_q == S_INIT);
  assign CoreStart  = (state_q != S_RUN);
  assign Ack        = ack_q;
  assign Busy       = busy_q;
  assign Timeout    = tout_q;
  assign CycleCount = cnt_q;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with a behavioural 256x8 data memory; expects
// TOUT behaviour when RUN_CTRL_TIMEOUT_EN is defined and saturation otherwise.
module tb_run_ctrl;

  localparam int CNT_W = 5;
  localparam int MAX_C = 20;
  localparam int INIT_C = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_INIT = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_TOUT = 3'd4;

  logic             Clk, Reset, Start;
  logic             HostReq, HostWrEn;
  logic [7:0]       HostAddr, HostWrData;
  logic             HostGnt;
  logic [7:0]       HostRdData;
  logic             CoreDone, CoreMemWrEn;
  logic [7:0]       CoreMemAddr, CoreMemWrData, CoreRdData;
  logic             CoreReset, CoreStart;
  logic             DmWrEn;
  logic [7:0]       DmAddr, DmWrData, DmRdData;
  logic             Ack, Busy, Timeout;
  logic [CNT_W-1:0] CycleCount;
  logic [2:0]       DbgState;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];

  run_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_C), .INIT_CYCLES(INIT_C)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .HostReq(HostReq), .HostWrEn(HostWrEn), .HostAddr(HostAddr), .HostWrData(HostWrData),
    .HostGnt(HostGnt), .HostRdData(HostRdData),
    .CoreDone(CoreDone), .CoreMemWrEn(CoreMemWrEn), .CoreMemAddr(CoreMemAddr),
    .CoreMemWrData(CoreMemWrData), .CoreRdData(CoreRdData),
    .CoreReset(CoreReset), .CoreStart(CoreStart),
    .DmWrEn(DmWrEn), .DmAddr(DmAddr), .DmWrData(DmWrData), .DmRdData(DmRdData),
    .Ack(Ack), .Busy(Busy), .Timeout(Timeout), .CycleCount(CycleCount), .DbgState(DbgState)
  );

  // clock / memory model
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign DmRdData = mem[DmAddr];
  always @(posedge Clk) if (DmWrEn) mem[DmAddr] <= DmWrData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b0; Start = 1'b0; HostReq = 1'b0; HostWrEn = 1'b0;
    HostAddr = 8'h00; HostWrData = 8'h00; CoreDone = 1'b0; CoreMemWrEn = 1'b0;
    CoreMemAddr = 8'h00; CoreMemWrData = 8'h00;

    // reset state
    #2;
    chk("rst_state", DbgState, ST_IDLE);
    chk("rst_core_reset", CoreReset, 1);
    chk("rst_core_start", CoreStart, 1);
    chk("rst_ack", Ack, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_timeout", Timeout, 0);
    chk("rst_count", CycleCount, 0);
    nxt();
    Reset = 1'b1;

    // host write/read in IDLE
    HostReq = 1'b1; HostWrEn = 1'b1; HostAddr = 8'd1; HostWrData = 8'h03;
    #1;
    chk("idle_host_gnt", HostGnt, 1);
    chk("idle_dm_wren", DmWrEn, 1);
    chk("idle_dm_addr", DmAddr, 8'd1);
    nxt();
    HostWrEn = 1'b0;
    #1;
    chk("idle_host_rd1", HostRdData, 8'h03);
    HostAddr = 8'd54; HostWrData = 8'd15; HostWrEn = 1'b1;
    nxt();
    HostWrEn = 1'b0;
    #1;
    chk("idle_host_rd54", HostRdData, 8'd15);

    // start blocked by host request
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("blocked_state", DbgState, ST_IDLE);
      chk("blocked_busy", Busy, 0);
    end
    HostReq = 1'b0;
    nxt();
    Start = 1'b0;
    chk("init1_state", DbgState, ST_INIT);
    chk("init1_core_reset", CoreReset, 1);
    chk("init1_busy", Busy, 1);
    CoreMemWrEn = 1'b1; CoreMemAddr = 8'd5; CoreMemWrData = 8'h55;
    #1;
    chk("init_dm_wren", DmWrEn, 0);
    chk("init_dm_addr", DmAddr, 8'd5);
    CoreMemWrEn = 1'b0;
    nxt();
    chk("init2_state", DbgState, ST_INIT);
    chk("init2_core_reset", CoreReset, 1);
    nxt();
    chk("run1_state", DbgState, ST_RUN);
    chk("run1_core_reset", CoreReset, 0);
    chk("run1_core_start", CoreStart, 0);
    chk("run1_count", CycleCount, 0);

    // core write wins over host during RUN
    CoreMemWrEn = 1'b1; CoreMemAddr = 8'd7; CoreMemWrData = 8'd9;
    HostReq = 1'b1; HostWrEn = 1'b1; HostAddr = 8'd7; HostWrData = 8'hAA;
    #1;
    chk("run_host_gnt", HostGnt, 0);
    chk("run_dm_wren", DmWrEn, 1);
    chk("run_dm_wdata", DmWrData, 8'd9);
    nxt();
    CoreMemWrEn = 1'b0; HostReq = 1'b0; HostWrEn = 1'b0;
    #1;
    chk("run_core_rd7", CoreRdData, 8'd9);
    wait_n(3);
    chk("run5_count", CycleCount, 4);
    CoreDone = 1'b1;
    nxt();
    CoreDone = 1'b0;
    chk("done_state", DbgState, ST_DONE);
    chk("done_ack", Ack, 1);
    chk("done_busy", Busy, 0);
    chk("done_count", CycleCount, 5);
    chk("done_core_reset", CoreReset, 0);
    chk("done_core_start", CoreStart, 1);
    chk("done_timeout", Timeout, 0);
    HostReq = 1'b1; HostAddr = 8'd7;
    #1;
    chk("done_host_gnt", HostGnt, 1);
    chk("done_host_rd7", HostRdData, 8'd9);

    // relaunch, then async reset mid-run at count 7
    HostReq = 1'b0; Start = 1'b1;
    nxt();
    Start = 1'b0;
    chk("relaunch_state", DbgState, ST_INIT);
    chk("relaunch_ack", Ack, 0);
    chk("relaunch_count", CycleCount, 0);
    wait_n(2);
    wait_n(7);
    chk("midrun_count", CycleCount, 7);
    Reset = 1'b0;
    #1;
    chk("areset_state", DbgState, ST_IDLE);
    chk("areset_core_reset", CoreReset, 1);
    chk("areset_busy", Busy, 0);
    chk("areset_count", CycleCount, 0);
    Reset = 1'b1;
    HostReq = 1'b1; HostAddr = 8'd54;
    #1;
    chk("areset_mem54", HostRdData, 8'd15);

    // run with no CoreDone: timeout or saturation
    nxt();
    HostReq = 1'b0; Start = 1'b1;
    nxt();
    Start = 1'b0;
    wait_n(2);
    wait_n(19);
    chk("run20_count", CycleCount, 19);
    chk("run20_busy", Busy, 1);
    nxt();
`ifdef RUN_CTRL_TIMEOUT_EN
    chk("tout_state", DbgState, ST_TOUT);
    chk("tout_timeout", Timeout, 1);
    chk("tout_ack", Ack, 0);
    chk("tout_busy", Busy, 0);
    chk("tout_count", CycleCount, 20);
    chk("tout_core_start", CoreStart, 1);
    HostReq = 1'b1;
    #1;
    chk("tout_host_gnt", HostGnt, 1);
    HostReq = 1'b0;
`else
    chk("notout_state", DbgState, ST_RUN);
    chk("notout_timeout", Timeout, 0);
    chk("notout_count", CycleCount, 20);
    wait_n(15);
    chk("sat_count", CycleCount, 31);
    chk("sat_busy", Busy, 1);
    chk("sat_timeout", Timeout, 0);
    CoreDone = 1'b1;
    nxt();
    CoreDone = 1'b0;
    chk("sat_done_ack", Ack, 1);
    chk("sat_done_count", CycleCount, 31);
`endif

    // CoreDone on cycle 20 wins over timeout
    Start = 1'b1;
    nxt();
    Start = 1'b0;
    chk("run3_init_timeout", Timeout, 0);
    chk("run3_init_ack", Ack, 0);
    wait_n(2);
    wait_n(19);
    CoreDone = 1'b1;
    nxt();
    CoreDone = 1'b0;
    chk("dwin_state", DbgState, ST_DONE);
    chk("dwin_ack", Ack, 1);
    chk("dwin_timeout", Timeout, 0);
    chk("dwin_count", CycleCount, 20);

    // back-to-back launch from DONE
    Start = 1'b1;
    nxt();
    Start = 1'b0;
    chk("b2b_state", DbgState, ST_INIT);
    chk("b2b_ack", Ack, 0);
    chk("b2b_busy", Busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
